// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode feeding a 2-entry elastic buffer (output reg + skid reg).
// Optional macro DECODE_ILLEGAL_EN: flag unsupported encodings on out_illegal (otherwise tied 0, decoded as NOP).
package decode_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
  } alu_op_t;

  typedef enum logic [1:0] {SRC_RS1 = 2'd0, SRC_PC, SRC_ZERO} alu_srcA_t;
  typedef enum logic [1:0] {SRC_RS2 = 2'd0, SRC_IMM, SRC_FOUR} alu_srcB_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] imm;
    alu_op_t     alu_op;
    alu_srcA_t   srcA;
    alu_srcB_t   srcB;
    logic        is_branch;
    logic        is_jump;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } bundle_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output alu_op_t         out_alu_op,
  output alu_srcA_t       out_srcA,
  output alu_srcB_t       out_srcB,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_illegal
);
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_is_op, w_f7_zero, w_f7_ok;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_ok, w_wr;
  bundle_t     w_dec;

  assign w_f3      = in_instr[14:12];
  assign w_f7      = in_instr[31:25];
  assign w_is_op   = (in_instr[6:0] == OPC_OP);
  assign w_f7_zero = (w_f7 == 7'h00);
  // OP-IMM non-shift forms carry immediate bits in funct7, so only OP constrains it
  assign w_f7_ok   = ~w_is_op | w_f7_zero;

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.rs1 = in_instr[19:15];
    w_dec.rs2 = in_instr[24:20];
    w_dec.rd  = in_instr[11:7];
    w_ok      = 1'b1;
    w_wr      = 1'b0;
    case (in_instr[6:0])
      OPC_LUI:   begin w_dec.srcA = SRC_ZERO; w_dec.srcB = SRC_IMM; w_dec.imm = w_imm_u; w_wr = 1'b1; end
      OPC_AUIPC: begin w_dec.srcA = SRC_PC; w_dec.srcB = SRC_IMM; w_dec.imm = w_imm_u; w_wr = 1'b1; end
      OPC_JAL: begin
        w_dec.srcA = SRC_PC; w_dec.srcB = SRC_FOUR; w_dec.is_jump = 1'b1;
        w_dec.imm = w_imm_j; w_wr = 1'b1;
      end
      OPC_JALR: begin
        w_dec.srcA = SRC_PC; w_dec.srcB = SRC_FOUR; w_dec.is_jump = 1'b1;
        w_dec.imm = w_imm_i; w_wr = 1'b1;
      end
      OPC_LOAD:  begin w_dec.srcB = SRC_IMM; w_dec.imm = w_imm_i; w_dec.mem_rd = 1'b1; w_wr = 1'b1; end
      OPC_STORE: begin w_dec.srcB = SRC_IMM; w_dec.imm = w_imm_s; w_dec.mem_wr = 1'b1; end
      OPC_BRANCH: begin
        w_dec.is_branch = 1'b1;
        w_dec.imm       = w_imm_b;
        case (w_f3)
          3'b000:  w_dec.alu_op = ALU_BEQ;
          3'b001:  w_dec.alu_op = ALU_BNE;
          3'b100:  w_dec.alu_op = ALU_BLT;
          3'b101:  w_dec.alu_op = ALU_BGE;
          3'b110:  w_dec.alu_op = ALU_BLTU;
          3'b111:  w_dec.alu_op = ALU_BGEU;
          default: w_ok = 1'b0;
        endcase
      end
      OPC_OPIMM, OPC_OP: begin
        w_wr = 1'b1;
        if (!w_is_op) begin
          w_dec.srcB = SRC_IMM;
          w_dec.imm  = w_imm_i;
        end
        case (w_f3)
          3'b000: begin
            if (w_is_op && w_f7 == 7'h20) w_dec.alu_op = ALU_SUB;
            else if (w_f7_ok)             w_dec.alu_op = ALU_ADD;
            else                          w_ok = 1'b0;
          end
          3'b001:  if (w_f7_zero) w_dec.alu_op = ALU_SLL; else w_ok = 1'b0;
          3'b010:  if (w_f7_ok)   w_dec.alu_op = ALU_SLT; else w_ok = 1'b0;
          3'b100:  if (w_f7_ok)   w_dec.alu_op = ALU_XOR; else w_ok = 1'b0;
          3'b101:  if (w_f7_zero) w_dec.alu_op = ALU_SRL; else w_ok = 1'b0;
          3'b110:  if (w_f7_ok)   w_dec.alu_op = ALU_OR;  else w_ok = 1'b0;
          3'b111:  if (w_f7_ok)   w_dec.alu_op = ALU_AND; else w_ok = 1'b0;
          default: w_ok = 1'b0;
        endcase
      end
      default: w_ok = 1'b0;
    endcase
    w_dec.rd_we = w_wr & (in_instr[11:7] != 5'd0);
    // Unsupported encodings collapse to a side-effect-free ADD bundle
    if (!w_ok) begin
      w_dec.imm       = '0;
      w_dec.alu_op    = ALU_ADD;
      w_dec.srcA      = SRC_RS1;
      w_dec.srcB      = SRC_RS2;
      w_dec.rd_we     = 1'b0;
      w_dec.is_branch = 1'b0;
      w_dec.is_jump   = 1'b0;
      w_dec.mem_rd    = 1'b0;
      w_dec.mem_wr    = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      w_dec.illegal   = 1'b1;
`else
      w_dec.illegal   = 1'b0;
`endif
    end
  end

  bundle_t r_out, r_skid;
  logic    r_out_valid, r_skid_valid, r_in_ready;
  logic    w_accept, w_consume, w_out_free;

  assign w_accept   = in_valid & r_in_ready;
  assign w_consume  = r_out_valid & out_ready;
  assign w_out_free = ~r_out_valid | w_consume;

  // Skid can only be occupied while the output is held, so accept never races a skid drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
        r_in_ready   <= 1'b1;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
      r_in_ready   <= 1'b0;
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_pc        = r_out.pc;
  assign out_rs1       = r_out.rs1;
  assign out_rs2       = r_out.rs2;
  assign out_rd        = r_out.rd;
  assign out_rd_we     = r_out.rd_we;
  assign out_imm       = r_out.imm;
  assign out_alu_op    = r_out.alu_op;
  assign out_srcA      = r_out.srcA;
  assign out_srcB      = r_out.srcB;
  assign out_is_branch = r_out.is_branch;
  assign out_is_jump   = r_out.is_jump;
  assign out_mem_rd    = r_out.mem_rd;
  assign out_mem_wr    = r_out.mem_wr;
  assign out_illegal   = r_out.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic against a queue-based reference model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_is_branch, out_is_jump, out_mem_rd, out_mem_wr, out_illegal;
  alu_op_t     out_alu_op;
  alu_srcA_t   out_srcA;
  alu_srcB_t   out_srcB;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_srcA(out_srcA),
    .out_srcB(out_srcB), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_illegal(out_illegal)
  );

  bundle_t dut_b;
  always_comb begin
    dut_b           = '0;
    dut_b.pc        = out_pc;
    dut_b.rs1       = out_rs1;
    dut_b.rs2       = out_rs2;
    dut_b.rd        = out_rd;
    dut_b.rd_we     = out_rd_we;
    dut_b.imm       = out_imm;
    dut_b.alu_op    = out_alu_op;
    dut_b.srcA      = out_srcA;
    dut_b.srcB      = out_srcB;
    dut_b.is_branch = out_is_branch;
    dut_b.is_jump   = out_is_jump;
    dut_b.mem_rd    = out_mem_rd;
    dut_b.mem_wr    = out_mem_wr;
    dut_b.illegal   = out_illegal;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam alu_op_t ARITH_TAB [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_ADD, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam alu_op_t BR_TAB    [0:7] = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  localparam logic [6:0] OPCS   [0:11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};

  // Reference decode straight from the ISA field definitions
  function automatic bundle_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b;
    logic ok, wr;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] sx, ii, is, ib, iu, ij;
    f3 = ins[14:12];
    f7 = ins[31:25];
    sx = ins[31] ? 32'hFFFFFFFF : 32'h0;
    ii = (ins >> 20) | (sx & 32'hFFFFF000);
    is = (ii & ~32'h1F) | ((ins >> 7) & 32'h1F);
    ib = (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1) | (sx & 32'hFFFFF000);
    iu = ins & 32'hFFFFF000;
    ij = (ins & 32'h000FF000) | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1) | (sx & 32'hFFF00000);
    b = '0;
    b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
    ok = 1'b1; wr = 1'b1;
    case (ins[6:0])
      7'h37: begin b.srcA = SRC_ZERO; b.srcB = SRC_IMM; b.imm = iu; end
      7'h17: begin b.srcA = SRC_PC; b.srcB = SRC_IMM; b.imm = iu; end
      7'h6F: begin b.srcA = SRC_PC; b.srcB = SRC_FOUR; b.is_jump = 1'b1; b.imm = ij; end
      7'h67: begin b.srcA = SRC_PC; b.srcB = SRC_FOUR; b.is_jump = 1'b1; b.imm = ii; end
      7'h03: begin b.srcB = SRC_IMM; b.imm = ii; b.mem_rd = 1'b1; end
      7'h23: begin b.srcB = SRC_IMM; b.imm = is; b.mem_wr = 1'b1; wr = 1'b0; end
      7'h63: begin b.is_branch = 1'b1; b.imm = ib; wr = 1'b0; b.alu_op = BR_TAB[f3]; ok = (f3 != 3'd2) && (f3 != 3'd3); end
      7'h13: begin
        b.srcB = SRC_IMM; b.imm = ii; b.alu_op = ARITH_TAB[f3];
        ok = (f3 != 3'd3) && ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00);
      end
      7'h33: begin
        b.alu_op = (f3 == 3'd0 && f7 == 7'h20) ? ALU_SUB : ARITH_TAB[f3];
        ok = (f3 != 3'd3) && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0));
      end
      default: ok = 1'b0;
    endcase
    b.rd_we = wr && (ins[11:7] != 5'd0);
    if (!ok) begin
      b.imm = '0; b.alu_op = ALU_ADD; b.srcA = SRC_RS1; b.srcB = SRC_RS2;
      b.rd_we = 1'b0; b.is_branch = 1'b0; b.is_jump = 1'b0; b.mem_rd = 1'b0; b.mem_wr = 1'b0;
`ifdef DECODE_ILLEGAL_EN
      b.illegal = 1'b1;
`endif
    end
    return b;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 12);
    if (k < 12) x[6:0] = OPCS[k];
    if ((x[6:0] == 7'h33 || x[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 7) == 0) x[11:7] = 5'd0;
    return x;
  endfunction

  // Entries held by the stage, oldest first
  bundle_t q[$];

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic r);
    logic can_in, has_out;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = rdy; flush = fl; rst = r;
    can_in  = (q.size() < 2);
    has_out = (q.size() > 0);
    if (r || fl) q.delete();
    else begin
      if (has_out && rdy) void'(q.pop_front());
      if (v && can_in) q.push_back(ref_dec(ins, pc));
    end
    @(negedge clk);
    chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) chk("bundle", 128'(dut_b), 128'(q[0]));
  endtask

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_SRA  = 32'h403150B3;
  localparam logic [31:0] I_A    = 32'h00100113;
  localparam logic [31:0] I_B    = 32'h00200193;

  initial begin
    logic [31:0] pc;
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, I_ADDI, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("rst_bundle", 128'(dut_b), 128'(0));

    cycle(1'b1, I_ADDI, 32'h100, 1'b1, 1'b0, 1'b0);
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_op", 128'(out_alu_op), 128'(ALU_ADD));
    chk("addi_srcA", 128'(out_srcA), 128'(SRC_RS1));
    chk("addi_srcB", 128'(out_srcB), 128'(SRC_IMM));
    chk("addi_imm", 128'(out_imm), 128'(5));
    chk("addi_rd", 128'(out_rd), 128'(1));
    chk("addi_rdwe", 128'(out_rd_we), 128'(1));
    chk("addi_pc", 128'(out_pc), 128'(32'h100));

    cycle(1'b1, I_SUB, 32'h104, 1'b1, 1'b0, 1'b0);
    chk("sub_op", 128'(out_alu_op), 128'(ALU_SUB));
    chk("sub_srcB", 128'(out_srcB), 128'(SRC_RS2));
    chk("sub_regs", 128'({out_rs1, out_rs2, out_rd}), 128'({5'd1, 5'd2, 5'd3}));

    cycle(1'b1, I_BNE, 32'h108, 1'b1, 1'b0, 1'b0);
    chk("bne_op", 128'(out_alu_op), 128'(ALU_BNE));
    chk("bne_br", 128'(out_is_branch), 128'(1));
    chk("bne_imm", 128'(out_imm), 128'(8));
    chk("bne_rdwe", 128'(out_rd_we), 128'(0));

    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, I_A, 32'h200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, I_B, 32'h204, 1'b0, 1'b0, 1'b0);
    chk("stall_inrdy", 128'(in_ready), 128'(0));
    chk("stall_pc0", 128'(out_pc), 128'(32'h200));
    cycle(1'b1, I_SUB, 32'h208, 1'b0, 1'b0, 1'b0);
    chk("stall_hold", 128'(out_pc), 128'(32'h200));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_pc1", 128'({out_valid, out_pc}), 128'({1'b1, 32'h204}));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 128'(out_valid), 128'(0));

    cycle(1'b1, I_A, 32'h300, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, I_B, 32'h304, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, I_SUB, 32'h308, 1'b0, 1'b1, 1'b0);
    chk("flush_ov", 128'(out_valid), 128'(0));
    chk("flush_ir", 128'(in_ready), 128'(1));
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_gone", 128'(out_valid), 128'(0));

    cycle(1'b1, I_SRA, 32'h400, 1'b1, 1'b0, 1'b0);
`ifdef DECODE_ILLEGAL_EN
    chk("sra_illegal", 128'(out_illegal), 128'(1));
`else
    chk("sra_illegal", 128'(out_illegal), 128'(0));
`endif
    chk("sra_rdwe", 128'(out_rd_we), 128'(0));

    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      logic v, rdy, fl, r;
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = ($urandom_range(0, 49) == 0);
      r   = ($urandom_range(0, 199) == 0);
      cycle(v, gen_instr(), pc, rdy, fl, r);
      pc = pc + 32'd4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
